estagio_escrita_flags: RTL and testbench

- Sits directly downstream of the ULA in the 16-bit datapath and consumes its per-instruction output: `resultadoOp`, Z/C/S/O and the 5-bit `controle` code.
- Holds the architectural flags register. It updates only the flags that the operation class is allowed to touch.
- Buffers results for register-file write-back in a 2-entry valid/ready skid buffer.
- Evaluates branch conditions from the committed flags.

---
 rtl/pkg_ula.sv | 60 ++++++
 rtl/fila_skid2.sv | 61 ++++++
 rtl/estagio_escrita_flags.sv | 88 ++++++++
 tb/tb_estagio_escrita_flags.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pkg_ula.sv
// Shared ULA definitions: controle opcodes, flag bit positions,
// branch condition codes and the per-opcode flag update mask.
package pkg_ula;

   localparam int unsigned bits_controle = 5;
   localparam int unsigned num_flags     = 4;
   localparam int unsigned bits_cond     = 4;

   // controle opcodes (shared with the ULA)
   localparam logic [bits_controle-1:0] ula_add    = 5'b00000;
   localparam logic [bits_controle-1:0] ula_adc    = 5'b00001;
   localparam logic [bits_controle-1:0] ula_sub    = 5'b00011;
   localparam logic [bits_controle-1:0] ula_sbb    = 5'b00100;
   localparam logic [bits_controle-1:0] ula_cmp    = 5'b00101;
   localparam logic [bits_controle-1:0] ula_neg    = 5'b00110;
   localparam logic [bits_controle-1:0] ula_shl    = 5'b01000;
   localparam logic [bits_controle-1:0] ula_shr    = 5'b01001;
   localparam logic [bits_controle-1:0] ula_pass_b = 5'b10000;
   localparam logic [bits_controle-1:0] ula_and    = 5'b10001;
   localparam logic [bits_controle-1:0] ula_const  = 5'b10011;
   localparam logic [bits_controle-1:0] ula_xor    = 5'b10101;
   localparam logic [bits_controle-1:0] ula_zero   = 5'b11111;

   // bit positions inside the {Z,C,S,O} flags vector
   localparam int unsigned flag_z = 3;
   localparam int unsigned flag_c = 2;
   localparam int unsigned flag_s = 1;
   localparam int unsigned flag_o = 0;

   // cond_sel encoding
   localparam logic [bits_cond-1:0] cond_sempre = 4'b0000;
   localparam logic [bits_cond-1:0] cond_z      = 4'b0001;
   localparam logic [bits_cond-1:0] cond_s      = 4'b0010;
   localparam logic [bits_cond-1:0] cond_c      = 4'b0011;
   localparam logic [bits_cond-1:0] cond_o      = 4'b0100;
   localparam logic [bits_cond-1:0] cond_z_ou_s = 4'b0101;
   localparam logic [bits_cond-1:0] cond_nz     = 4'b0110;
   localparam logic [bits_cond-1:0] cond_ns     = 4'b0111;
   localparam logic [bits_cond-1:0] cond_nc     = 4'b1000;
   localparam logic [bits_cond-1:0] cond_no     = 4'b1001;
   localparam logic [bits_cond-1:0] cond_nz_ns  = 4'b1010;

   // Which of {Z,C,S,O} an operation class is allowed to overwrite
   function automatic logic [num_flags-1:0] mascara_flags(input logic [bits_controle-1:0] c);
      logic [num_flags-1:0] m;
      m = 4'b0000;
      case (c)
         ula_add, ula_adc, ula_sub, ula_sbb, ula_cmp, ula_neg: m = 4'b1111;
         ula_shl, ula_shr:                                     m = 4'b1110;
         ula_pass_b, ula_const, ula_zero:                      m = 4'b0000;
         default: begin
            // remaining 1xxxx are logic ops; unlisted 0xxxx leave flags alone
            if (c[4]) m = 4'b1010;
            else      m = 4'b0000;
         end
      endcase
      return m;
   endfunction

endpackage

// File: rtl/fila_skid2.sv
// Generic 2-entry valid/ready skid buffer, FIFO order, with flush.
// Ports: clk, rst (sync, active high), limpa (flush),
//        ent_valido/ent_pronto/ent_dado (upstream),
//        sai_valido/sai_pronto/sai_dado (downstream, head entry).
module fila_skid2 #(
   parameter int unsigned largura = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               limpa,
   input  logic               ent_valido,
   output logic               ent_pronto,
   input  logic [largura-1:0] ent_dado,
   output logic               sai_valido,
   input  logic               sai_pronto,
   output logic [largura-1:0] sai_dado
);

   logic [1:0]         cont;
   logic [1:0]         cont_prox;
   logic [largura-1:0] seg;
   logic               push;
   logic               pop;

   assign push = ent_valido && ent_pronto;
   assign pop  = sai_valido && sai_pronto;

   // occupancy after this edge (flush handled in the register block)
   always_comb begin
      cont_prox = cont;
      if (push && !pop)      cont_prox = 2'(cont + 2'd1);
      else if (pop && !push) cont_prox = 2'(cont - 2'd1);
   end

   // sai_dado is the head register; seg holds the second entry
   always_ff @(posedge clk) begin
      if (rst) begin
         cont       <= '0;
         sai_dado   <= '0;
         seg        <= '0;
         sai_valido <= 1'b0;
         ent_pronto <= 1'b1;
      end else if (limpa) begin
         cont       <= '0;
         sai_valido <= 1'b0;
         ent_pronto <= 1'b1;
      end else begin
         cont       <= cont_prox;
         sai_valido <= (cont_prox != 2'd0);
         ent_pronto <= (cont_prox != 2'd2);
         if (pop) begin
            if (push)              sai_dado <= ent_dado;
            else if (cont == 2'd2) sai_dado <= seg;
         end else if (push) begin
            if (cont == 2'd0) sai_dado <= ent_dado;
            else              seg      <= ent_dado;
         end
      end
   end

endmodule

// File: rtl/estagio_escrita_flags.sv
// Write-back / flags stage behind the ULA: commits masked flags on accept,
// buffers {result, dest, escreve} in a 2-entry skid buffer, and evaluates
// branch conditions from the committed flags.
// Ports: clk, rst; ent_valido/ent_pronto + resultadoOp, Z/C/S/O, controle,
//        dest, escreve (from ULA); limpa (flush); wb_valido/wb_pronto,
//        wb_dado, wb_dest, wb_escreve (to register file); flags;
//        cond_sel -> cond_ok.
module estagio_escrita_flags
   import pkg_ula::*;
#(
   parameter int unsigned bits_palavra = 16,
   parameter int unsigned bits_end     = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ent_valido,
   output logic                     ent_pronto,
   input  logic [bits_palavra-1:0]  resultadoOp,
   input  logic                     Z,
   input  logic                     C,
   input  logic                     S,
   input  logic                     O,
   input  logic [bits_controle-1:0] controle,
   input  logic [bits_end-1:0]      dest,
   input  logic                     escreve,
   input  logic                     limpa,
   output logic                     wb_valido,
   input  logic                     wb_pronto,
   output logic [bits_palavra-1:0]  wb_dado,
   output logic [bits_end-1:0]      wb_dest,
   output logic                     wb_escreve,
   output logic [num_flags-1:0]     flags,
   input  logic [bits_cond-1:0]     cond_sel,
   output logic                     cond_ok
);

   localparam int unsigned largura = bits_palavra + bits_end + 1;

   logic                 aceita;
   logic [num_flags-1:0] mascara;
   logic [num_flags-1:0] flags_ula;
   logic [largura-1:0]   entrada;
   logic [largura-1:0]   saida;

   assign aceita    = ent_valido && ent_pronto;
   assign mascara   = mascara_flags(controle);
   assign flags_ula = {Z, C, S, O};
   assign entrada   = {resultadoOp, dest, escreve};
   assign {wb_dado, wb_dest, wb_escreve} = saida;

   fila_skid2 #(.largura(largura)) u_fila (
      .clk        (clk),
      .rst        (rst),
      .limpa      (limpa),
      .ent_valido (ent_valido),
      .ent_pronto (ent_pronto),
      .ent_dado   (entrada),
      .sai_valido (wb_valido),
      .sai_pronto (wb_pronto),
      .sai_dado   (saida)
   );

   // masked flag commit; a flushed entry never touches the flags
   always_ff @(posedge clk) begin
      if (rst)                  flags <= '0;
      else if (aceita && !limpa) flags <= (flags & ~mascara) | (flags_ula & mascara);
   end

   // branch condition from committed flags only
   always_comb begin
      cond_ok = 1'b0;
      case (cond_sel)
         cond_sempre: cond_ok = 1'b1;
         cond_z:      cond_ok = flags[flag_z];
         cond_s:      cond_ok = flags[flag_s];
         cond_c:      cond_ok = flags[flag_c];
         cond_o:      cond_ok = flags[flag_o];
         cond_z_ou_s: cond_ok = flags[flag_z] | flags[flag_s];
         cond_nz:     cond_ok = !flags[flag_z];
         cond_ns:     cond_ok = !flags[flag_s];
         cond_nc:     cond_ok = !flags[flag_c];
         cond_no:     cond_ok = !flags[flag_o];
         cond_nz_ns:  cond_ok = !(flags[flag_z] | flags[flag_s]);
         default:     cond_ok = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_estagio_escrita_flags.sv
module tb_estagio_escrita_flags;

   logic        clk = 1'b0;
   logic        rst;
   logic        ent_valido;
   logic        ent_pronto;
   logic [15:0] resultadoOp;
   logic        Z, C, S, O;
   logic [4:0]  controle;
   logic [2:0]  dest;
   logic        escreve;
   logic        limpa;
   logic        wb_valido;
   logic        wb_pronto;
   logic [15:0] wb_dado;
   logic [2:0]  wb_dest;
   logic        wb_escreve;
   logic [3:0]  flags;
   logic [3:0]  cond_sel;
   logic        cond_ok;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   estagio_escrita_flags dut (
      .clk(clk), .rst(rst), .ent_valido(ent_valido), .ent_pronto(ent_pronto),
      .resultadoOp(resultadoOp), .Z(Z), .C(C), .S(S), .O(O),
      .controle(controle), .dest(dest), .escreve(escreve), .limpa(limpa),
      .wb_valido(wb_valido), .wb_pronto(wb_pronto), .wb_dado(wb_dado),
      .wb_dest(wb_dest), .wb_escreve(wb_escreve), .flags(flags),
      .cond_sel(cond_sel), .cond_ok(cond_ok)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cond(input logic [3:0] sel, input logic exp, input string tag);
      cond_sel = sel;
      #1;
      chk(tag, 32'(cond_ok), 32'(exp));
   endtask

   task automatic ula(input logic [15:0] r, input logic [4:0] ctl, input logic [3:0] zcso,
                      input logic [2:0] d, input logic e);
      ent_valido  = 1'b1;
      resultadoOp = r;
      controle    = ctl;
      {Z, C, S, O} = zcso;
      dest        = d;
      escreve     = e;
   endtask

   initial begin
      rst = 1'b1; ent_valido = 1'b0; resultadoOp = '0; {Z, C, S, O} = 4'b0;
      controle = '0; dest = '0; escreve = 1'b0; limpa = 1'b0;
      wb_pronto = 1'b0; cond_sel = 4'b0000;

      // reset state
      tick();
      chk("rst_wb_valido", 32'(wb_valido), 32'd0);
      chk("rst_ent_pronto", 32'(ent_pronto), 32'd1);
      chk("rst_flags", 32'(flags), 32'd0);
      chk("rst_wb_dado", 32'(wb_dado), 32'd0);
      rst = 1'b0;

      // 1: compare class updates all four flags
      ula(16'h0000, 5'b00101, 4'b1100, 3'd3, 1'b1);
      tick();
      ent_valido = 1'b0;
      chk("t1_flags", 32'(flags), 32'hC);
      cond(4'b0001, 1'b1, "t1_cond_z");
      chk("t1_wb_valido", 32'(wb_valido), 32'd1);
      chk("t1_wb_dado", 32'(wb_dado), 32'h0);
      chk("t1_wb_dest", 32'(wb_dest), 32'd3);
      chk("t1_wb_escreve", 32'(wb_escreve), 32'd1);
      wb_pronto = 1'b1;
      tick();
      chk("t1_pop_valido", 32'(wb_valido), 32'd0);

      // 2: logic op holds C and O
      ula(16'h1234, 5'b00000, 4'b1111, 3'd1, 1'b1);
      tick();
      chk("t2_flags_all", 32'(flags), 32'hF);
      ula(16'h0000, 5'b10001, 4'b0000, 3'd2, 1'b1);
      tick();
      ent_valido = 1'b0;
      chk("t2_flags_and", 32'(flags), 32'h5);
      cond(4'b0011, 1'b1, "t2_cond_c");
      cond(4'b0100, 1'b1, "t2_cond_o");
      cond(4'b0110, 1'b1, "t2_cond_nz");

      // 3: shift holds O, constant and unlisted change nothing, xor is logic
      ula(16'h0000, 5'b00000, 4'b0000, 3'd0, 1'b1);
      tick();
      chk("t3_flags_zero", 32'(flags), 32'h0);
      ula(16'h8000, 5'b01000, 4'b0111, 3'd0, 1'b1);
      tick();
      chk("t3_flags_shl", 32'(flags), 32'h6);
      cond(4'b1010, 1'b0, "t3_cond_nzns");
      cond(4'b0101, 1'b1, "t3_cond_zs");
      ula(16'h0000, 5'b10011, 4'b1000, 3'd0, 1'b1);
      tick();
      chk("t3_flags_const", 32'(flags), 32'h6);
      ula(16'h0042, 5'b00010, 4'b1111, 3'd5, 1'b1);
      tick();
      chk("t3_flags_unlisted", 32'(flags), 32'h6);
      chk("t3_unlisted_buffered", 32'(wb_dado), 32'h0042);
      ula(16'h0000, 5'b10101, 4'b1001, 3'd0, 1'b1);
      tick();
      ent_valido = 1'b0;
      chk("t3_flags_xor", 32'(flags), 32'hC);
      cond(4'b1011, 1'b0, "t3_cond_1011");
      cond(4'b0111, 1'b1, "t3_cond_ns");
      cond(4'b1000, 1'b0, "t3_cond_nc");
      cond(4'b1001, 1'b1, "t3_cond_no");
      cond(4'b1111, 1'b0, "t3_cond_1111");
      tick();
      chk("t3_drained", 32'(wb_valido), 32'd0);

      // 4: stall with full buffer, then drain in order
      wb_pronto = 1'b0;
      ula(16'h0001, 5'b10000, 4'b1111, 3'd1, 1'b1);
      tick();
      chk("t4_dado1", 32'(wb_dado), 32'h0001);
      chk("t4_pronto1", 32'(ent_pronto), 32'd1);
      ula(16'h0002, 5'b10000, 4'b1111, 3'd2, 1'b0);
      tick();
      chk("t4_pronto_full", 32'(ent_pronto), 32'd0);
      ula(16'h0003, 5'b10000, 4'b1111, 3'd3, 1'b1);
      tick();
      chk("t4_stall_dado", 32'(wb_dado), 32'h0001);
      chk("t4_stall_pronto", 32'(ent_pronto), 32'd0);
      wb_pronto = 1'b1;
      tick();
      chk("t4_out2", 32'(wb_dado), 32'h0002);
      chk("t4_out2_escreve", 32'(wb_escreve), 32'd0);
      chk("t4_pronto_again", 32'(ent_pronto), 32'd1);
      tick();
      ent_valido = 1'b0;
      chk("t4_out3", 32'(wb_dado), 32'h0003);
      chk("t4_out3_valido", 32'(wb_valido), 32'd1);
      chk("t4_flags_held", 32'(flags), 32'hC);
      tick();
      chk("t4_empty", 32'(wb_valido), 32'd0);

      // 5: flush discards buffer and incoming entry, flags preserved
      wb_pronto = 1'b0;
      ula(16'h0010, 5'b10000, 4'b0000, 3'd1, 1'b1);
      tick();
      chk("t5_count1", 32'(wb_valido), 32'd1);
      ula(16'h8000, 5'b00000, 4'b0001, 3'd2, 1'b1);
      limpa = 1'b1;
      tick();
      limpa = 1'b0;
      ent_valido = 1'b0;
      chk("t5_valido", 32'(wb_valido), 32'd0);
      chk("t5_flags", 32'(flags), 32'hC);
      chk("t5_pronto", 32'(ent_pronto), 32'd1);

      // 6: reset mid-stall with two entries buffered
      ula(16'hAAAA, 5'b00000, 4'b1111, 3'd7, 1'b1);
      tick();
      ula(16'hBBBB, 5'b00000, 4'b1111, 3'd6, 1'b1);
      tick();
      ent_valido = 1'b0;
      chk("t6_full", 32'(ent_pronto), 32'd0);
      chk("t6_flags_pre", 32'(flags), 32'hF);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_valido", 32'(wb_valido), 32'd0);
      chk("t6_dado", 32'(wb_dado), 32'd0);
      chk("t6_dest", 32'(wb_dest), 32'd0);
      chk("t6_escreve", 32'(wb_escreve), 32'd0);
      chk("t6_flags", 32'(flags), 32'd0);
      chk("t6_pronto", 32'(ent_pronto), 32'd1);
      cond(4'b0000, 1'b1, "t6_cond_sempre");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
